inv_sub_bytes_serial: RTL and testbench
=======================================

// Module: inv_sub_bytes_serial
// PURPOSE
//  AES InvSubBytes for the decrypt datapath; inverse of the forward byte S-box block.
//  Takes a 128-bit state on a valid/ready handshake and substitutes every byte through a shared inverse S-box.
//  Processes LANES bytes per cycle, so area and switching power trade against latency.
//  The enable input freezes all state.
//  Sits between InvShiftRows and AddRoundKey in the decryption round.
// PARAMETERS
//  LANES  1  inverse S-box instances; bytes substituted per cycle; legal values 1,2,4,8,16
// PORTS
//  clock      in   1    single clock; all flops on rising edge
//  reset      in   1    asynchronous, active-low reset
//  enable     in   1    1 = run; 0 = freeze FSM, counter and registers (clock-gate equivalent)
//  in_valid   in   1    blocoIn is valid
//  in_ready   out  1    block can accept a state
//  blocoIn    in   128  input state; byte k = bits [127-8k -: 8], k=0..15
//  out_valid  out  1    blocoOut holds a completed result
//  out_ready  in   1    downstream accepts blocoOut
//  blocoOut   out  128  InvSBox applied to each byte of the accepted state, same byte order
//  busy       out  1    FSM is in RUN
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE, counter 0, data register 0.
//   Outputs during reset: blocoOut=0, out_valid=0, busy=0, in_ready=0.
//  Clock, reset and enable are fixed as listed in PORTS.
//  in_ready = enable & (state==IDLE). This is the only combinational output.
//  FSM:
//   IDLE -> RUN when in_valid & in_ready. On that edge, load blocoIn into data register and set cnt=0.
//   RUN, each enabled cycle:
//    - bytes cnt*LANES .. cnt*LANES+LANES-1 are replaced in place by InvSBox(byte).
//    - cnt increments. cnt width = clog2(16/LANES), minimum 1 bit.
//    - when cnt == 16/LANES-1 the last group is written; go to DONE.
//   DONE: out_valid=1, blocoOut = data register.
//    - DONE -> IDLE on an enabled cycle with out_ready=1.
//  Latency, accept edge to out_valid: 16/LANES cycles, i.e. 16 for LANES=1 and 1 for LANES=16.
//  Throughput: at most one state per 16/LANES+2 cycles. No accept in the same cycle as the DONE->IDLE exit.
//  blocoOut is stable while out_valid=1. It holds the partially substituted state during RUN; consumers ignore it then.
//  enable=0:
//   - no register changes; in_ready=0.
//   - out_valid holds its value, but no handshake completes.
//   - resume continues from the exact byte group where it stopped.
//  out_ready while not in DONE: ignored. in_valid while not IDLE: ignored; the source must hold it.
//  InvSBox is the FIPS-197 inverse table, a 256x8 constant ROM per lane; it is the exact inverse of the forward S-box.
//   Spot values: 63->00, 7C->01, 00->52, 16->FF, FF->7D.
//  Reset asserted mid-RUN or in DONE: operation aborted, result discarded, all outputs go to reset values immediately.
//  Illegal LANES: elaboration error via a generate-time check.
// TESTING
//  1 Reset: hold reset=0 with random inputs -> blocoOut=0, out_valid=0, in_ready=0, busy=0.
//    Release reset -> in_ready=1 on the next cycle.
//  2 Known-answer vector, LANES=1:
//    blocoIn=D42711AEE0BF98F1B8B45DE51E415230 -> after 16 cycles out_valid=1,
//    blocoOut=193DE3BEA0F4E22B9AC68D2AE9F84808 (FIPS-197 App.B round 1).
//    Repeat with LANES=4 (4 cycles) and LANES=16 (1 cycle).
//  3 Round trip: 1000 random states through the forward S-box then this block -> output equals the original state.
//    Exhaustive check: all 256 byte values in each byte lane.
//  4 Backpressure: blocoIn=all 63 bytes, hold out_ready=0 for 10 cycles -> blocoOut=0, out_valid stays 1, in_ready=0.
//    Assert out_ready -> returns to IDLE and in_ready=1 on the next cycle.
//  5 Enable gating: drop enable for 5 cycles at cnt=7 (LANES=1) -> registers frozen, in_ready=0.
//    Total latency becomes 21 cycles; result is still correct.
//  6 Reset mid-RUN at cnt=9 -> all outputs go to reset values immediately.
//    Next state accepted after reset completes normally with the correct result.

Source files
------------

// File: rtl/inv_sub_bytes_serial_if.sv
// Valid/ready state stream for InvSubBytes: 128-bit state in, substituted 128-bit state out.
// The slave modport is the substitution block; the master modport is its neighbour or a bench.
interface inv_sub_bytes_serial_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] blocoIn;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] blocoOut;

   modport slave (
      input  in_valid,
      input  blocoIn,
      input  out_ready,
      output in_ready,
      output out_valid,
      output blocoOut
   );

   modport master (
      output in_valid,
      output blocoIn,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  blocoOut
   );
endinterface

// File: rtl/inv_sub_bytes_serial.sv
// Serial AES InvSubBytes: replaces LANES bytes of the captured state per enabled cycle
// through per-lane inverse S-box ROMs, in place, finishing after 16/LANES cycles.
module inv_sub_bytes_serial #(
   parameter int unsigned LANES = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enable,
   inv_sub_bytes_serial_if.slave bus,
   output logic                 busy
);

   localparam int unsigned Groups = (LANES == 0) ? 1 : 16 / LANES;
   localparam int unsigned CntW   = (Groups > 1) ? $clog2(Groups) : 1;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16))
   begin : g_lanes_check
      $error("inv_sub_bytes_serial: LANES must be 1, 2, 4, 8 or 16");
   end

   localparam logic [7:0] InvSbox [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
      8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
      8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
      8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
      8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
      8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
      8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
      8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
      8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
      8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
      8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
      8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
      8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
      8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
      8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
      8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
      8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   logic [1:0]      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [127:0]    data_q, data_d;
   logic [127:0]    sub_data;

   // Byte k lives at bits [127-8k -: 8]; lanes cover bytes cnt*LANES .. cnt*LANES+LANES-1.
   always_comb begin
      int unsigned idx;
      logic [6:0]  lsb;
      idx      = 0;
      lsb      = '0;
      sub_data = data_q;
      for (int unsigned l = 0; l < LANES; l++) begin
         idx                = int'(unsigned'(cnt_q)) * LANES + l;
         lsb                = 7'(8 * (15 - idx));
         sub_data[lsb +: 8] = InvSbox[data_q[lsb +: 8]];
      end
   end

   // With enable low every register simply holds.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      if (enable) begin
         case (state_q)
            StIdle: begin
               if (bus.in_valid) begin
                  state_d = StRun;
                  cnt_d   = '0;
                  data_d  = bus.blocoIn;
               end
            end
            StRun: begin
               data_d = sub_data;
               if (cnt_q == CntW'(Groups - 1)) begin
                  cnt_d   = '0;
                  state_d = StDone;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
            StDone: begin
               if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end

   // in_ready is forced low while reset is held, even though the FSM already sits in IDLE.
   assign bus.in_ready  = reset & enable & (state_q == StIdle);
   assign bus.out_valid = (state_q == StDone);
   assign bus.blocoOut  = data_q;
   assign busy          = (state_q == StRun);

endmodule

// File: tb/tb_inv_sub_bytes_serial.sv
// Bench for inv_sub_bytes_serial: LANES = 1, 4 and 16 side by side against a transaction-level
// model whose inverse S-box is derived from GF(2^8) arithmetic rather than a copied table.
module tb_inv_sub_bytes_serial;

   logic clock  = 1'b0;
   logic reset  = 1'b0;
   logic enable = 1'b0;
   always #5 clock = ~clock;

   logic         iv   [3];
   logic [127:0] bi   [3];
   logic         ordy [3];
   logic         ir   [3];
   logic         ov   [3];
   logic         bz   [3];
   logic [127:0] bo   [3];

   inv_sub_bytes_serial_if bus0 ();
   inv_sub_bytes_serial_if bus1 ();
   inv_sub_bytes_serial_if bus2 ();

   assign bus0.in_valid = iv[0];
   assign bus0.blocoIn = bi[0];
   assign bus0.out_ready = ordy[0];
   assign ir[0] = bus0.in_ready;
   assign ov[0] = bus0.out_valid;
   assign bo[0] = bus0.blocoOut;
   assign bus1.in_valid = iv[1];
   assign bus1.blocoIn = bi[1];
   assign bus1.out_ready = ordy[1];
   assign ir[1] = bus1.in_ready;
   assign ov[1] = bus1.out_valid;
   assign bo[1] = bus1.blocoOut;
   assign bus2.in_valid = iv[2];
   assign bus2.blocoIn = bi[2];
   assign bus2.out_ready = ordy[2];
   assign ir[2] = bus2.in_ready;
   assign ov[2] = bus2.out_valid;
   assign bo[2] = bus2.blocoOut;

   inv_sub_bytes_serial #(.LANES(1)) u_l1 (
      .clock(clock), .reset(reset), .enable(enable), .bus(bus0), .busy(bz[0]));
   inv_sub_bytes_serial #(.LANES(4)) u_l4 (
      .clock(clock), .reset(reset), .enable(enable), .bus(bus1), .busy(bz[1]));
   inv_sub_bytes_serial #(.LANES(16)) u_l16 (
      .clock(clock), .reset(reset), .enable(enable), .bus(bus2), .busy(bz[2]));

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int acc [3];
   bit rand_phase = 1'b0;

   logic [7:0] fwd_t [256];
   logic [7:0] inv_t [256];

   // Transaction model: one pending state per instance, done after 16/LANES enabled cycles.
   bit           pend [3];
   int           rem  [3];
   logic [127:0] expv [3];

   function automatic int lanes_of(input int i);
      return (i == 0) ? 1 : ((i == 1) ? 4 : 16);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   function automatic logic [7:0] fwd_calc(input logic [7:0] x);
      logic [7:0] y;
      y = 8'h00;
      for (int c = 1; c < 256; c++) if (gmul(x, 8'(c)) == 8'h01) y = 8'(c);
      return y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] map_state(input logic [127:0] d_in, input bit use_inv);
      logic [127:0] d, r;
      d = d_in; r = '0;
      for (int k = 0; k < 16; k++) begin
         r = {r[119:0], use_inv ? inv_t[d[127:120]] : fwd_t[d[127:120]]};
         d = d << 8;
      end
      return r;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic chk(input string nm, input int inst, input logic [127:0] got,
                      input logic [127:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s (inst %0d) at cycle %0d: actual %h, required %h",
                  nm, inst, cyc, got, want);
      end
   endtask

   task automatic send(input int i, input logic [127:0] d);
      int b;
      b = 0;
      iv[i] = 1'b1;
      bi[i] = d;
      forever begin
         @(negedge clock);
         if (ir[i]) break;
         b++;
         if (b > 5000) begin
            chk("accept_timeout", i, 128'(0), 128'(1));
            iv[i] = 1'b0;
            return;
         end
      end
      @(posedge clock);
      #2;
      acc[i] = cyc;
      iv[i]  = 1'b0;
   endtask

   task automatic recv(input int i, output logic [127:0] d, output int lat, input int dly);
      int b;
      b = 0;
      repeat (dly) begin @(posedge clock); #2; end
      ordy[i] = 1'b1;
      forever begin
         @(negedge clock);
         if (ov[i] && enable) break;
         b++;
         if (b > 5000) begin
            chk("out_valid_timeout", i, 128'(0), 128'(1));
            ordy[i] = 1'b0;
            d = '0;
            lat = -1;
            return;
         end
      end
      d   = bo[i];
      lat = cyc - acc[i];
      @(posedge clock);
      #2;
      ordy[i] = 1'b0;
   endtask

   task automatic xfer(input int i, input logic [127:0] din, output logic [127:0] d,
                       output int lat);
      send(i, din);
      recv(i, d, lat, 0);
   endtask

   task automatic rt(input int i);
      logic [127:0] orig, din, res;
      int lat;
      for (int n = 0; n < 1256; n++) begin
         din = '0;
         if (n < 1000) begin
            orig = rnd128();
            din  = map_state(orig, 1'b0);
         end else begin
            for (int k = 0; k < 16; k++) din = {din[119:0], 8'(n - 1000 + 17 * k)};
            orig = map_state(din, 1'b1);
         end
         repeat ($urandom_range(0, 2)) begin @(posedge clock); #2; end
         send(i, din);
         recv(i, res, lat, int'($urandom_range(0, 3)));
         chk("roundtrip", i, res, orig);
      end
   endtask

   initial forever begin
      @(posedge clock);
      cyc++;
   end

   initial forever begin
      @(posedge clock or negedge reset);
      for (int i = 0; i < 3; i++) begin
         if (!reset) begin
            pend[i] = 1'b0;
         end else if (enable) begin
            if (pend[i] && rem[i] > 0) begin
               rem[i]--;
            end else if (pend[i]) begin
               if (ordy[i]) pend[i] = 1'b0;
            end else if (iv[i]) begin
               pend[i] = 1'b1;
               rem[i]  = 16 / lanes_of(i);
               expv[i] = map_state(bi[i], 1'b1);
            end
         end
      end
   end

   initial forever begin
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
         logic xr, xv, xb;
         xr = reset && enable && !pend[i];
         xv = reset && pend[i] && (rem[i] == 0);
         xb = reset && pend[i] && (rem[i] > 0);
         chk("in_ready", i, 128'(ir[i]), 128'(xr));
         chk("out_valid", i, 128'(ov[i]), 128'(xv));
         chk("busy", i, 128'(bz[i]), 128'(xb));
         if (!reset) chk("blocoOut_in_reset", i, bo[i], '0);
         else if (xv) chk("blocoOut", i, bo[i], expv[i]);
      end
   end

   initial forever begin
      @(posedge clock);
      #2;
      if (rand_phase) enable = ($urandom_range(0, 9) != 0);
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, actual running, required finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [127:0] res [3];
      int           lat [3];
      logic [127:0] dd  [3];
      logic [127:0] kat_in, kat_out, frozen;
      kat_in  = 128'hD42711AEE0BF98F1B8B45DE51E415230;
      kat_out = 128'h193DE3BEA0F4E22B9AC68D2AE9F84808;
      frozen  = '0;
      for (int i = 0; i < 3; i++) begin
         iv[i] = 1'b0; bi[i] = '0; ordy[i] = 1'b0;
      end
      for (int x = 0; x < 256; x++) fwd_t[x] = fwd_calc(8'(x));
      for (int x = 0; x < 256; x++) inv_t[fwd_t[x]] = 8'(x);

      chk("model_63", -1, 128'(inv_t[8'h63]), 128'(8'h00));
      chk("model_7c", -1, 128'(inv_t[8'h7c]), 128'(8'h01));
      chk("model_00", -1, 128'(inv_t[8'h00]), 128'(8'h52));
      chk("model_16", -1, 128'(inv_t[8'h16]), 128'(8'hff));
      chk("model_ff", -1, 128'(inv_t[8'hff]), 128'(8'h7d));
      chk("model_kat", -1, map_state(kat_in, 1'b1), kat_out);

      // Reset held with random inputs
      repeat (6) begin
         @(posedge clock);
         #2;
         for (int i = 0; i < 3; i++) begin
            iv[i] = 1'($urandom_range(0, 1));
            bi[i] = rnd128();
            ordy[i] = 1'($urandom_range(0, 1));
         end
         enable = 1'($urandom_range(0, 1));
      end
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
         chk("reset_blocoOut", i, bo[i], '0);
         chk("reset_out_valid", i, 128'(ov[i]), 128'(0));
         chk("reset_in_ready", i, 128'(ir[i]), 128'(0));
         chk("reset_busy", i, 128'(bz[i]), 128'(0));
      end
      @(posedge clock);
      #2;
      for (int i = 0; i < 3; i++) begin iv[i] = 1'b0; ordy[i] = 1'b0; end
      enable = 1'b1;
      reset  = 1'b1;
      @(negedge clock);
      for (int i = 0; i < 3; i++) chk("ready_after_reset", i, 128'(ir[i]), 128'(1));
      @(posedge clock);
      #2;

      // Known-answer vector on every lane count
      fork
         xfer(0, kat_in, res[0], lat[0]);
         xfer(1, kat_in, res[1], lat[1]);
         xfer(2, kat_in, res[2], lat[2]);
      join
      for (int i = 0; i < 3; i++) begin
         chk("kat_result", i, res[i], kat_out);
         chk("kat_latency", i, 128'(lat[i]), 128'(16 / lanes_of(i)));
      end

      // Backpressure with an all-0x63 state
      fork
         send(0, {16{8'h63}});
         send(1, {16{8'h63}});
         send(2, {16{8'h63}});
      join
      repeat (16) @(posedge clock);
      repeat (10) begin
         @(negedge clock);
         for (int i = 0; i < 3; i++) begin
            chk("bp_out_valid", i, 128'(ov[i]), 128'(1));
            chk("bp_blocoOut", i, bo[i], '0);
            chk("bp_in_ready", i, 128'(ir[i]), 128'(0));
         end
      end
      @(posedge clock);
      #2;
      fork
         recv(0, res[0], lat[0], 0);
         recv(1, res[1], lat[1], 0);
         recv(2, res[2], lat[2], 0);
      join
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
         chk("bp_result", i, res[i], '0);
         chk("bp_ready_after", i, 128'(ir[i]), 128'(1));
      end
      @(posedge clock);
      #2;

      // Enable dropped for 5 cycles once 7 bytes are done (LANES=1)
      send(0, kat_in);
      repeat (7) @(posedge clock);
      #2;
      enable = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         if (k == 0) begin
            frozen = bo[0];
            chk("freeze_partial", 0, frozen, {kat_out[127:72], kat_in[71:0]});
         end else begin
            chk("freeze_hold", 0, bo[0], frozen);
         end
         chk("freeze_in_ready", 1, 128'(ir[1]), 128'(0));
         @(posedge clock);
      end
      #2;
      enable = 1'b1;
      recv(0, res[0], lat[0], 0);
      chk("freeze_result", 0, res[0], kat_out);
      chk("freeze_latency", 0, 128'(lat[0]), 128'(21));

      // Reset mid-RUN (LANES=1 at cnt 9; the others sit in DONE)
      for (int i = 0; i < 3; i++) dd[i] = rnd128();
      fork
         send(0, dd[0]);
         send(1, dd[1]);
         send(2, dd[2]);
      join
      repeat (9) @(posedge clock);
      #2;
      reset = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("abort_blocoOut", i, bo[i], '0);
         chk("abort_out_valid", i, 128'(ov[i]), 128'(0));
         chk("abort_in_ready", i, 128'(ir[i]), 128'(0));
         chk("abort_busy", i, 128'(bz[i]), 128'(0));
      end
      repeat (2) @(posedge clock);
      #2;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) dd[i] = rnd128();
      fork
         xfer(0, dd[0], res[0], lat[0]);
         xfer(1, dd[1], res[1], lat[1]);
         xfer(2, dd[2], res[2], lat[2]);
      join
      for (int i = 0; i < 3; i++) begin
         chk("post_abort_result", i, res[i], map_state(dd[i], 1'b1));
         chk("post_abort_latency", i, 128'(lat[i]), 128'(16 / lanes_of(i)));
      end

      // Random round trips plus every byte value in every lane, with random enable gaps
      rand_phase = 1'b1;
      fork
         rt(0);
         rt(1);
         rt(2);
      join
      rand_phase = 1'b0;
      @(posedge clock);
      #2;
      enable = 1'b1;
      repeat (3) @(posedge clock);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
